// File: rtl/sda_kernel_ctrl_master.sv
// AXI4-Lite initiator that starts an SDAccel kernel (ap_start) and polls its control register for ap_done.
// Every channel handshakes on a rising edge with VALID && READY; a raised VALID and its payload hold until that edge.
module sda_kernel_ctrl_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 6,
    parameter int unsigned CTRL_REG_ADDR  = 0,
    parameter int unsigned POLL_INTERVAL  = 16,
    parameter int unsigned MAX_POLLS      = 0
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      cmd_go_valid,
    output logic                      cmd_go_ready,
    output logic                      cmd_done_valid,
    input  logic                      cmd_done_ready,
    output logic [1:0]                cmd_status,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_control_AWADDR,
    output logic                      m_axi_control_AWVALID,
    input  logic                      m_axi_control_AWREADY,
    output logic [31:0]               m_axi_control_WDATA,
    output logic [3:0]                m_axi_control_WSTRB,
    output logic                      m_axi_control_WVALID,
    input  logic                      m_axi_control_WREADY,
    input  logic [1:0]                m_axi_control_BRESP,
    input  logic                      m_axi_control_BVALID,
    output logic                      m_axi_control_BREADY,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_control_ARADDR,
    output logic                      m_axi_control_ARVALID,
    input  logic                      m_axi_control_ARREADY,
    input  logic [31:0]               m_axi_control_RDATA,
    input  logic [1:0]                m_axi_control_RRESP,
    input  logic                      m_axi_control_RVALID,
    output logic                      m_axi_control_RREADY,
    output logic [2:0]                dbg_state
);
    localparam int PCW = (MAX_POLLS == 0) ? 1 : $clog2(MAX_POLLS + 1);
    localparam int IW  = (POLL_INTERVAL <= 1) ? 1 : $clog2(POLL_INTERVAL);
    localparam logic [IW-1:0] IVL_LAST = IW'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_POLL_WAIT, S_RD_REQ, S_RD_RESP, S_DONE
    } state_t;

    state_t         state;
    logic [IW-1:0]  ivl_cnt;
    logic [PCW-1:0] poll_cnt;
    logic [PCW-1:0] poll_inc;
    logic           timeout_hit;
    logic           aw_done;
    logic           w_done;
    logic           unused_rdata;

    assign m_axi_control_AWADDR = AXI_ADDR_WIDTH'(CTRL_REG_ADDR);
    assign m_axi_control_ARADDR = AXI_ADDR_WIDTH'(CTRL_REG_ADDR);
    assign m_axi_control_WDATA  = 32'h1;
    assign m_axi_control_WSTRB  = 4'hF;
    assign dbg_state            = 3'(state);
    assign unused_rdata         = ^{m_axi_control_RDATA[31:2], m_axi_control_RDATA[0]};

    // Poll count saturates so a huge MAX_POLLS-free run never wraps into a false timeout.
    always_comb begin
        poll_inc = poll_cnt;
        if (poll_cnt != {PCW{1'b1}}) poll_inc = poll_cnt + PCW'(1);
    end

    assign timeout_hit = (MAX_POLLS != 0) && (32'(poll_inc) == MAX_POLLS);
    assign aw_done     = !m_axi_control_AWVALID || m_axi_control_AWREADY;
    assign w_done      = !m_axi_control_WVALID  || m_axi_control_WREADY;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state                 <= S_IDLE;
            cmd_go_ready          <= 1'b0;
            cmd_done_valid        <= 1'b0;
            cmd_status            <= 2'd0;
            m_axi_control_AWVALID <= 1'b0;
            m_axi_control_WVALID  <= 1'b0;
            m_axi_control_BREADY  <= 1'b0;
            m_axi_control_ARVALID <= 1'b0;
            m_axi_control_RREADY  <= 1'b0;
            ivl_cnt               <= '0;
            poll_cnt              <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_go_valid && cmd_go_ready) begin
                        cmd_go_ready          <= 1'b0;
                        m_axi_control_AWVALID <= 1'b1;
                        m_axi_control_WVALID  <= 1'b1;
                        poll_cnt              <= '0;
                        state                 <= S_WR_REQ;
                    end else begin
                        cmd_go_ready <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    if (m_axi_control_AWVALID && m_axi_control_AWREADY) m_axi_control_AWVALID <= 1'b0;
                    if (m_axi_control_WVALID && m_axi_control_WREADY) m_axi_control_WVALID <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axi_control_BREADY <= 1'b1;
                        state                <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (m_axi_control_BVALID) begin
                        m_axi_control_BREADY <= 1'b0;
                        if (m_axi_control_BRESP != 2'b00) begin
                            cmd_status     <= 2'd1;
                            cmd_done_valid <= 1'b1;
                            state          <= S_DONE;
                        end else begin
                            ivl_cnt <= '0;
                            state   <= S_POLL_WAIT;
                        end
                    end
                end
                S_POLL_WAIT: begin
                    if (ivl_cnt == IVL_LAST) begin
                        m_axi_control_ARVALID <= 1'b1;
                        state                 <= S_RD_REQ;
                    end else begin
                        ivl_cnt <= ivl_cnt + IW'(1);
                    end
                end
                S_RD_REQ: begin
                    if (m_axi_control_ARREADY) begin
                        m_axi_control_ARVALID <= 1'b0;
                        m_axi_control_RREADY  <= 1'b1;
                        state                 <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (m_axi_control_RVALID) begin
                        m_axi_control_RREADY <= 1'b0;
                        poll_cnt             <= poll_inc;
                        // Error beats done, done beats timeout.
                        if (m_axi_control_RRESP != 2'b00) begin
                            cmd_status     <= 2'd2;
                            cmd_done_valid <= 1'b1;
                            state          <= S_DONE;
                        end else if (m_axi_control_RDATA[1]) begin
                            cmd_status     <= 2'd0;
                            cmd_done_valid <= 1'b1;
                            state          <= S_DONE;
                        end else if (timeout_hit) begin
                            cmd_status     <= 2'd3;
                            cmd_done_valid <= 1'b1;
                            state          <= S_DONE;
                        end else begin
                            ivl_cnt <= '0;
                            state   <= S_POLL_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    if (cmd_done_ready) begin
                        cmd_done_valid <= 1'b0;
                        cmd_go_ready   <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
